mips_multicycle_control: RTL

Sequencing controller for the multicycle variant of the MIPS core. It replaces the single-cycle combinational control unit with a Moore/Mealy state machine that steps each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the shared-memory, IR, PC, register-file and ALU-mux enables of the multicycle datapath. It also handshakes with a single unified instruction/data memory that may stall.

---
 rtl/mips_multicycle_control.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Sequencing controller for the multicycle MIPS datapath. Each instruction
// goes through fetch, decode, execute, memory and writeback states. The
// controller handshakes with one unified instruction/data memory that may
// stall. A per-state wait counter turns a memory that never answers into a
// sticky FAULT state.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   opcode      instruction[31:26] from the IR
//   zero        ALU zero flag
//   mem_ready   memory accepts/completes the current access this cycle
//   iord        memory address select (0 = PC, 1 = ALUOut)
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    IR load enable (follows mem_ready in FETCH)
//   pc_en       PC load = pc_write | (pc_write_cond & zero)
//   reg_dst     register-file write select (1 = rd)
//   mem_to_reg  writeback select (1 = MDR)
//   reg_write   register-file write enable
//   alu_src_a   ALU A select (0 = PC, 1 = A)
//   alu_src_b   ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_op      00 add, 01 sub, 10 funct-decoded
//   pc_source   00 ALU result, 01 ALUOut, 10 jump target
//   instr_done  one-cycle pulse in the last cycle of each instruction
//   fault       high while in FAULT (held until reset)
//   state       current state code, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t     r_state;
    logic [7:0] r_wait_cnt;

    state_t     w_next_normal;
    state_t     w_next;
    logic       w_mem_state;
    logic       w_timeout;

    logic       w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic       w_pc_write, w_pc_write_cond;
    logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
    logic       w_instr_done, w_fault;

    // States that wait on the memory handshake and therefore can time out.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == LP_TIMEOUT);
    // A timeout overrides the normal stall hold; a ready on the limit cycle wins.
    assign w_next      = w_timeout ? S_FAULT : w_next_normal;

    // Next-state selection without the timeout override.
    always_comb begin
        w_next_normal = S_FAULT;
        case (r_state)
            S_FETCH:  w_next_normal = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW:    w_next_normal = S_MEMADR;
                    OP_SW:    w_next_normal = S_MEMADR;
                    OP_RTYPE: w_next_normal = S_EXEC;
                    OP_BEQ:   w_next_normal = S_BRANCH;
                    OP_J:     w_next_normal = S_JUMP;
                    OP_ADDI:  w_next_normal = S_ADDIEX;
                    default:  w_next_normal = S_FAULT;
                endcase
            end
            S_MEMADR: w_next_normal = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_normal = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next_normal = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_normal = S_ALUWB;
            S_ADDIEX: w_next_normal = S_ADDIWB;
            S_MEMWB:  w_next_normal = S_FETCH;
            S_ALUWB:  w_next_normal = S_FETCH;
            S_ADDIWB: w_next_normal = S_FETCH;
            S_BRANCH: w_next_normal = S_FETCH;
            S_JUMP:   w_next_normal = S_FETCH;
            default:  w_next_normal = S_FAULT;
        endcase
    end

    // State register and memory wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_mem_state && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    // Per-state control decode; only ir_write, pc_write and instr_done look at mem_ready.
    always_comb begin
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;
        w_fault         = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = mem_ready;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_source     = 2'b01;
                w_pc_write_cond = 1'b1;
                w_instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_pc_source  = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_FAULT: w_fault = 1'b1;
            // Unused codes 12..14 look exactly like FAULT.
            default: w_fault = 1'b1;
        endcase
    end

    // Reset squashes every output in the same cycle so an aborted
    // instruction cannot write the register file, memory or PC.
    assign iord       = reset ? 1'b0  : w_iord;
    assign mem_read   = reset ? 1'b0  : w_mem_read;
    assign mem_write  = reset ? 1'b0  : w_mem_write;
    assign ir_write   = reset ? 1'b0  : w_ir_write;
    assign pc_en      = reset ? 1'b0  : (w_pc_write | (w_pc_write_cond & zero));
    assign reg_dst    = reset ? 1'b0  : w_reg_dst;
    assign mem_to_reg = reset ? 1'b0  : w_mem_to_reg;
    assign reg_write  = reset ? 1'b0  : w_reg_write;
    assign alu_src_a  = reset ? 1'b0  : w_alu_src_a;
    assign alu_src_b  = reset ? 2'b00 : w_alu_src_b;
    assign alu_op     = reset ? 2'b00 : w_alu_op;
    assign pc_source  = reset ? 2'b00 : w_pc_source;
    assign instr_done = reset ? 1'b0  : w_instr_done;
    assign fault      = reset ? 1'b0  : w_fault;
    assign state      = reset ? 4'd0  : r_state;

endmodule
